gayle_xfer_seq: RTL and testbench

PIO transfer sequencer for the Gayle IDE data path. It sits between the Gayle register decoder and the 4096×16 sector FIFO, and drives the FIFO read/write strobes and the FIFO clear. It paces the Amiga CPU with DRQ one 256-word sector at a time and requests host (ARM/SPI side) service to fill or drain the FIFO. It counts sectors and raises a per-sector interrupt.

---
 rtl/gayle_pkg.sv | 21 ++
 rtl/gayle_sec_cnt.sv | 35 +++
 rtl/gayle_xfer_seq.sv | 191 +++++++++++++++++++
 tb/tb_gayle_xfer_seq.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gayle_pkg.sv
// Shared types and constants for the Gayle IDE PIO transfer sequencer.
package gayle_pkg;

  localparam int SECTOR_WORDS_DEF = 256;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_XFER,
    ST_DRAIN
  } xfer_state_e;

  // A sector count of 0 on the task file means a full 256-sector transfer.
  function automatic logic [8:0] sector_load(input logic [7:0] count);
    return (count == 8'd0) ? 9'd256 : {1'b0, count};
  endfunction

endpackage

// File: rtl/gayle_sec_cnt.sv
// Loadable 9-bit down-counter holding the remaining sector count.
module gayle_sec_cnt (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       clr,
  input  logic       load,
  input  logic [8:0] load_val,
  input  logic       dec,
  output logic [8:0] count,
  output logic       zero,
  output logic       one
);

  logic [8:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (load) cnt_d = load_val;
    else if (dec)  cnt_d = cnt_q - 9'd1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only,
  // so every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt_q <= '0;
    else if (en)   cnt_q <= cnt_d;
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == 9'd0);
  assign one   = (cnt_q == 9'd1);

endmodule

// File: rtl/gayle_xfer_seq.sv
// PIO transfer sequencer between the Gayle register decoder and the sector FIFO.
// Define GAYLE_XFER_ERR_EN to build the sticky protocol-error flag.
module gayle_xfer_seq
  import gayle_pkg::*;
#(
  parameter int SECTOR_WORDS = SECTOR_WORDS_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk7_en,
  input  logic       cmd_start,
  input  logic       cmd_dir,
  input  logic [7:0] cmd_count,
  input  logic       abort,
  input  logic       cpu_data_rd,
  input  logic       cpu_data_wr,
  input  logic       irq_ack,
  input  logic       fifo_full,
  input  logic       fifo_empty,
  input  logic       fifo_last,
  output logic       fifo_rd,
  output logic       fifo_wr,
  output logic       fifo_clr,
  output logic       drq,
  output logic       busy,
  output logic       hst_req,
  output logic       irq,
  output logic [8:0] sectors_left,
  output logic       err
);

  localparam logic [7:0] LAST_WORD = 8'(SECTOR_WORDS - 1);

  xfer_state_e state_q, state_d;
  logic        dir_q, dir_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic        drq_q, drq_d;
  logic        busy_q, busy_d;
  logic        hst_req_q, hst_req_d;
  logic        irq_q, irq_d;
  logic        fifo_clr_q, fifo_clr_d;

  logic sec_clr, sec_load, sec_dec, sec_zero, sec_last, sector_done;

  // Strobes pass straight through, gated only by the registered drq.
  assign fifo_rd = cpu_data_rd & drq_q & (dir_q == DIR_RD);
  assign fifo_wr = cpu_data_wr & drq_q & (dir_q == DIR_WR);

  // NOTE: every variable written here gets a default first, so no path
  // through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    word_cnt_d  = word_cnt_q;
    drq_d       = drq_q;
    busy_d      = busy_q;
    hst_req_d   = hst_req_q;
    irq_d       = irq_q;
    fifo_clr_d  = 1'b0;
    sec_clr     = 1'b0;
    sec_load    = 1'b0;
    sector_done = 1'b0;

    unique case (state_q)
      ST_IDLE: if (cmd_start) begin
        fifo_clr_d = 1'b1;
        sec_load   = 1'b1;
        word_cnt_d = '0;
        busy_d     = 1'b1;
        dir_d      = cmd_dir;
        state_d    = (cmd_dir == DIR_RD) ? ST_FILL : ST_XFER;
        hst_req_d  = (cmd_dir == DIR_RD);
        drq_d      = (cmd_dir == DIR_WR);
      end
      ST_FILL: if (fifo_full) begin
        state_d   = ST_XFER;
        hst_req_d = 1'b0;
        drq_d     = 1'b1;
      end
      ST_XFER: begin
        if (dir_q == DIR_RD) begin
          if (fifo_rd && fifo_last) begin
            sector_done = 1'b1;
            drq_d       = 1'b0;
            state_d     = sec_last ? ST_IDLE : ST_FILL;
            busy_d      = !sec_last;
            hst_req_d   = !sec_last;
          end
        end else if (fifo_wr) begin
          word_cnt_d = word_cnt_q + 8'd1;
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d = '0;
            state_d    = ST_DRAIN;
            drq_d      = 1'b0;
            hst_req_d  = 1'b1;
          end
        end
      end
      ST_DRAIN: if (fifo_empty) begin
        sector_done = 1'b1;
        hst_req_d   = 1'b0;
        state_d     = sec_last ? ST_IDLE : ST_XFER;
        busy_d      = !sec_last;
        drq_d       = !sec_last;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything above, including a start in the same cycle.
    if (abort) begin
      state_d     = ST_IDLE;
      busy_d      = 1'b0;
      drq_d       = 1'b0;
      hst_req_d   = 1'b0;
      fifo_clr_d  = 1'b1;
      sec_clr     = 1'b1;
      sec_load    = 1'b0;
      sector_done = 1'b0;
    end else begin
      if (irq_ack)     irq_d = 1'b0;
      if (sector_done) irq_d = 1'b1;
    end
  end

  assign sec_dec = sector_done & ~sec_zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_RD;
      word_cnt_q <= '0;
      drq_q      <= 1'b0;
      busy_q     <= 1'b0;
      hst_req_q  <= 1'b0;
      irq_q      <= 1'b0;
      fifo_clr_q <= 1'b0;
    end else if (clk7_en) begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      word_cnt_q <= word_cnt_d;
      drq_q      <= drq_d;
      busy_q     <= busy_d;
      hst_req_q  <= hst_req_d;
      irq_q      <= irq_d;
      fifo_clr_q <= fifo_clr_d;
    end
  end

  gayle_sec_cnt u_sec_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (clk7_en),
    .clr      (sec_clr),
    .load     (sec_load),
    .load_val (sector_load(cmd_count)),
    .dec      (sec_dec),
    .count    (sectors_left),
    .zero     (sec_zero),
    .one      (sec_last)
  );

`ifdef GAYLE_XFER_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((cpu_data_rd || cpu_data_wr) && !drq_q && busy_q) err_d = 1'b1;
    if (state_q == ST_XFER &&
        ((dir_q == DIR_RD && cpu_data_wr) || (dir_q == DIR_WR && cpu_data_rd)))
      err_d = 1'b1;
    if (cmd_start && busy_q) err_d = 1'b1;
    if (cmd_start && !abort && state_q == ST_IDLE) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     err_q <= 1'b0;
    else if (clk7_en) err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign drq      = drq_q;
  assign busy     = busy_q;
  assign hst_req  = hst_req_q;
  assign irq      = irq_q;
  assign fifo_clr = fifo_clr_q;

endmodule

// File: tb/tb_gayle_xfer_seq.sv
// Scoreboard bench for gayle_xfer_seq: expected status changes are queued by
// the stimulus and matched in order by a negedge monitor.
module tb_gayle_xfer_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clk7_en = 1'b0;
  logic       cmd_start = 1'b0;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_count = '0;
  logic       abort = 1'b0;
  logic       cpu_data_rd = 1'b0;
  logic       cpu_data_wr = 1'b0;
  logic       irq_ack = 1'b0;
  logic       fifo_full, fifo_empty, fifo_last;
  logic       fifo_rd, fifo_wr, fifo_clr, drq, busy, hst_req, irq, err;
  logic [8:0] sectors_left;

  always #5 clk = ~clk;

  gayle_xfer_seq #(.SECTOR_WORDS(256)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clk7_en      (clk7_en),
    .cmd_start    (cmd_start),
    .cmd_dir      (cmd_dir),
    .cmd_count    (cmd_count),
    .abort        (abort),
    .cpu_data_rd  (cpu_data_rd),
    .cpu_data_wr  (cpu_data_wr),
    .irq_ack      (irq_ack),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_last    (fifo_last),
    .fifo_rd      (fifo_rd),
    .fifo_wr      (fifo_wr),
    .fifo_clr     (fifo_clr),
    .drq          (drq),
    .busy         (busy),
    .hst_req      (hst_req),
    .irq          (irq),
    .sectors_left (sectors_left),
    .err          (err)
  );

  // FIFO occupancy model; host fill/drain act as one-cycle bulk operations.
  // short_sec marks every word as a sector's last word.
  int   fcnt = 0;
  int   rd_ptr = 0;
  logic host_fill = 1'b0;
  logic host_drain = 1'b0;
  logic short_sec = 1'b0;

  assign fifo_full  = (fcnt >= 256);
  assign fifo_empty = (fcnt == 0);
  assign fifo_last  = (fcnt != 0) && (short_sec || (rd_ptr % 256 == 255));

  always @(posedge clk) begin
    if (clk7_en) begin
      if (fifo_clr) begin
        fcnt   <= 0;
        rd_ptr <= 0;
      end else if (host_fill) begin
        fcnt <= 256;
      end else if (host_drain) begin
        fcnt <= 0;
      end else begin
        fcnt   <= fcnt + int'(fifo_wr) - int'(fifo_rd);
        rd_ptr <= rd_ptr + int'(fifo_rd);
      end
    end
  end

  typedef struct packed {
    logic       drq;
    logic       busy;
    logic       hst;
    logic       irq;
    logic       clr;
    logic       err;
    logic [8:0] sl;
  } obs_t;

  obs_t q[$];
  obs_t model = '0;
  obs_t last_exp = '0;
  obs_t mon_prev = '0;
  obs_t mon_cur;
  obs_t mon_exp;

  int total = 0;
  int bad = 0;
  int n_rd = 0;
  int n_wr = 0;
  int n_irq = 0;

  function automatic string fmt(obs_t o);
    return $sformatf("drq=%0b busy=%0b hst=%0b irq=%0b clr=%0b err=%0b sl=%0d",
                     o.drq, o.busy, o.hst, o.irq, o.clr, o.err, o.sl);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Queue the model state if it differs from the last queued expectation.
  task automatic exp_update();
    if (model != last_exp) begin
      q.push_back(model);
      last_exp = model;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      mon_cur = {drq, busy, hst_req, irq, fifo_clr, err, sectors_left};
      n_rd += int'(fifo_rd);
      n_wr += int'(fifo_wr);
      if (mon_cur != mon_prev) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change: got %s expected no change", fmt(mon_cur));
        end else begin
          mon_exp = q.pop_front();
          if (mon_cur != mon_exp) begin
            bad++;
            $display("FAIL status_change: got %s expected %s", fmt(mon_cur), fmt(mon_exp));
          end
        end
      end
      if (mon_cur.irq && !mon_prev.irq) n_irq++;
      mon_prev = mon_cur;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_drq", int'(drq), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_hst_req", int'(hst_req), 0);
    check("reset_irq", int'(irq), 0);
    check("reset_fifo_clr", int'(fifo_clr), 0);
    check("reset_sectors_left", int'(sectors_left), 0);
    check("reset_err", int'(err), 0);
    check("reset_fifo_rd", int'(fifo_rd), 0);
    check("reset_fifo_wr", int'(fifo_wr), 0);

    // A start with the clock enable low must be ignored.
    cyc();
    cmd_count = 8'd1;
    cmd_start = 1'b1;
    cyc();
    cyc();
    cmd_start = 1'b0;
    clk7_en   = 1'b1;
    cyc();
    check("gated_start_busy", int'(busy), 0);

    // Read, one sector.
    model.busy = 1'b1; model.hst = 1'b1; model.clr = 1'b1; model.sl = 9'd1;
    exp_update();
    model.clr = 1'b0;
    exp_update();
    cmd_dir = 1'b0; cmd_count = 8'd1; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    cyc();
    model.drq = 1'b1; model.hst = 1'b0;
    exp_update();
    host_fill = 1'b1;
    cyc();
    host_fill = 1'b0;
    cyc();
    model.drq = 1'b0; model.busy = 1'b0; model.irq = 1'b1; model.sl = 9'd0;
    exp_update();
    n_rd = 0;
    cpu_data_rd = 1'b1;
    repeat (257) cyc();
    cpu_data_rd = 1'b0;
    check("rd1_fifo_rd_count", n_rd, 256);
    model.irq = 1'b0;
    exp_update();
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    cyc();

    // Write, two sectors; first completion coincides with an irq_ack.
    model.drq = 1'b1; model.busy = 1'b1; model.clr = 1'b1; model.sl = 9'd2;
    exp_update();
    model.clr = 1'b0;
    exp_update();
    cmd_dir = 1'b1; cmd_count = 8'd2; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    cyc();
    n_wr = 0;
    for (int s = 0; s < 2; s++) begin
      model.drq = 1'b0; model.hst = 1'b1;
      exp_update();
      cpu_data_wr = 1'b1;
      repeat (256) cyc();
      cpu_data_wr = 1'b0;
      check("wr_fifo_wr_count", n_wr, 256 * (s + 1));
      model.hst = 1'b0; model.irq = 1'b1; model.sl = 9'(1 - s);
      model.drq = (s == 0); model.busy = (s == 0);
      exp_update();
      host_drain = 1'b1;
      cyc();
      host_drain = 1'b0;
      irq_ack = (s == 0);
      cyc();
      irq_ack = 1'b0;
      cyc();
      check("irq_set_wins_over_ack", int'(irq), 1);
      model.irq = 1'b0;
      exp_update();
      irq_ack = 1'b1;
      cyc();
      irq_ack = 1'b0;
      cyc();
    end

    // Read of three sectors, stray strobe, ignored start, abort mid-sector.
    model.busy = 1'b1; model.hst = 1'b1; model.clr = 1'b1; model.sl = 9'd3;
    exp_update();
    model.clr = 1'b0;
    exp_update();
    cmd_dir = 1'b0; cmd_count = 8'd3; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    cyc();
`ifdef GAYLE_XFER_ERR_EN
    model.err = 1'b1;
    exp_update();
`endif
    n_rd = 0;
    cpu_data_rd = 1'b1;
    cyc();
    cpu_data_rd = 1'b0;
    check("stray_rd_no_fifo_rd", n_rd, 0);
    cmd_dir = 1'b1; cmd_count = 8'd5; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0; cmd_dir = 1'b0;
    check("start_while_busy_sl", int'(sectors_left), 3);
    model.drq = 1'b1; model.hst = 1'b0;
    exp_update();
    host_fill = 1'b1;
    cyc();
    host_fill = 1'b0;
    cyc();
    cpu_data_rd = 1'b1;
    repeat (100) cyc();
    cpu_data_rd = 1'b0;
    check("abort_pre_fifo_rd_count", n_rd, 100);
    model.drq = 1'b0; model.busy = 1'b0; model.clr = 1'b1; model.sl = 9'd0;
    exp_update();
    model.clr = 1'b0;
    exp_update();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    cyc();
    cyc();

    // Abort together with start in IDLE: only the FIFO clear happens.
    model.clr = 1'b1;
    exp_update();
    model.clr = 1'b0;
    exp_update();
    abort = 1'b1; cmd_start = 1'b1; cmd_count = 8'd4;
    cyc();
    abort = 1'b0; cmd_start = 1'b0;
    cyc();
    cyc();
    check("abort_beats_start_busy", int'(busy), 0);

    // Read with count 0: 256 one-word sectors, each interrupt acked.
    short_sec = 1'b1;
    n_irq = 0;
    model.busy = 1'b1; model.hst = 1'b1; model.clr = 1'b1; model.err = 1'b0;
    model.sl = 9'd256;
    exp_update();
    model.clr = 1'b0;
    exp_update();
    cmd_dir = 1'b0; cmd_count = 8'd0; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    cyc();
    for (int i = 0; i < 256; i++) begin
      model.drq = 1'b1; model.hst = 1'b0;
      exp_update();
      host_fill = 1'b1;
      cyc();
      host_fill = 1'b0;
      cyc();
      model.drq = 1'b0; model.irq = 1'b1; model.sl = 9'(255 - i);
      model.hst = (i != 255); model.busy = (i != 255);
      exp_update();
      cpu_data_rd = 1'b1;
      cyc();
      cpu_data_rd = 1'b0;
      model.irq = 1'b0;
      exp_update();
      irq_ack = 1'b1;
      cyc();
      irq_ack = 1'b0;
    end
    short_sec = 1'b0;
    repeat (4) cyc();
    check("count0_irq_count", n_irq, 256);
    check("count0_busy_end", int'(busy), 0);
    check("count0_sectors_left_end", int'(sectors_left), 0);
    check("scoreboard_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
